reaction_timer_ctrl: RTL and testbench

Controller for the reaction-timer game on the board. It sequences a pseudo-random wait after the player presses start, lights the stimulus LED, and then measures the player's reaction time in milliseconds. It flags early presses (cheat) and no-response (timeout). It sits between the debounced button pulses and the seven-segment display driver, which consumes `time_ms` and `state`.

---
 rtl/rt_pkg.sv | 20 ++
 rtl/lfsr16.sv | 33 +++
 rtl/reaction_timer_ctrl.sv | 143 ++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer controller.
// No logic; no latency.
// No flow control.
package rt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        TIMING  = 3'd2,
        DONE    = 3'd3,
        CHEAT   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [13:0] CHEAT_CODE = 14'd9999;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the random wait source.
// Output is the register value; advances every clock.
// No flow control; never stalls.
module lfsr16
    import rt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        // The all-zero lock-up state is unreachable from a non-zero seed; guard anyway.
        if (lfsr_d == 16'd0) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer FSM: random wait, stimulus LED, ms reaction measurement.
// All outputs registered; an input pulse is reflected one cycle later.
// No flow control; pulses are consumed in the cycle they arrive.
module reaction_timer_ctrl
    import rt_pkg::*;
#(
    parameter int TICK_DIV     = 100_000,
    parameter int MIN_DELAY_MS = 2000,
    parameter int DELAY_BITS   = 12,
    parameter int TIMEOUT_MS   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic        led,
    output logic [13:0] time_ms,
    output state_t      state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (MIN_DELAY_MS + (2 ** DELAY_BITS) - 1 >= 2 ** 16) begin : g_bad_delay
        $error("MIN_DELAY_MS + 2^DELAY_BITS - 1 does not fit the 16-bit delay counter");
    end
    if (TIMEOUT_MS > 9999) begin : g_bad_timeout
        $error("TIMEOUT_MS must not exceed 9999");
    end

    logic [15:0] lfsr_val;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val;

    state_t      state_q, state_d;
    logic        led_q, led_d;
    logic [13:0] time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0] dly_cnt_q, dly_cnt_d;
    logic [15:0] dly_ms_q, dly_ms_d;
    logic        tick;
    logic [15:0] dly_pick;

    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    assign dly_pick = 16'(MIN_DELAY_MS) + 16'(lfsr_val[DELAY_BITS-1:0]);

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        time_d    = time_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        dly_cnt_d = dly_cnt_q;
        dly_ms_d  = dly_ms_q;

        if (clear) begin
            state_d = IDLE;
            led_d   = 1'b0;
            time_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    led_d  = 1'b0;
                    time_d = '0;
                    if (start) begin
                        dly_ms_d  = dly_pick;
                        dly_cnt_d = '0;
                        presc_d   = '0;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    led_d = 1'b0;
                    if (stop) begin
                        state_d = CHEAT;
                        time_d  = CHEAT_CODE;
                    end else if (tick) begin
                        dly_cnt_d = dly_cnt_q + 16'd1;
                        if (dly_cnt_q == dly_ms_q - 16'd1) begin
                            state_d = TIMING;
                            led_d   = 1'b1;
                            time_d  = '0;
                            presc_d = '0;
                        end
                    end
                end
                TIMING: begin
                    led_d = 1'b1;
                    // stop beats a coincident tick so the shown time is what the player saw
                    if (stop) begin
                        state_d = DONE;
                        led_d   = 1'b0;
                    end else if (tick) begin
                        if (time_q == 14'(TIMEOUT_MS - 1)) begin
                            state_d = TIMEOUT;
                            led_d   = 1'b0;
                            time_d  = 14'(TIMEOUT_MS);
                        end else begin
                            time_d = time_q + 14'd1;
                        end
                    end
                end
                DONE, CHEAT, TIMEOUT: begin
                    led_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    led_d   = 1'b0;
                    time_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            led_q     <= 1'b0;
            time_q    <= '0;
            presc_q   <= '0;
            dly_cnt_q <= '0;
            dly_ms_q  <= '0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            dly_cnt_q <= dly_cnt_d;
            dly_ms_q  <= dly_ms_d;
        end
    end

    assign led     = led_q;
    assign time_ms = time_q;
    assign state   = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: directed game scenarios plus random pulses
// checked against a timestamp-based model of the game rules.
module tb_reaction_timer_ctrl;
    import rt_pkg::*;

    localparam int TD  = 4;
    localparam int MIN = 2;
    localparam int DB  = 3;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        led;
    logic [13:0] time_ms;
    state_t      state;

    int asserts = 0;
    int fails   = 0;

    reaction_timer_ctrl #(
        .TICK_DIV     (TD),
        .MIN_DELAY_MS (MIN),
        .DELAY_BITS   (DB),
        .TIMEOUT_MS   (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .led     (led),
        .time_ms (time_ms),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Model: game described by timestamps (first WAIT cycle, LED-rise cycle).
    logic [15:0] m_lfsr;
    int          now;
    state_t      m_st;
    int          m_e;
    int          m_t;
    logic [13:0] m_hold;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [13:0] exp_time();
        case (m_st)
            IDLE, WAIT: return 14'd0;
            TIMING:     return 14'((now - m_t) / TD);
            default:    return m_hold;
        endcase
    endfunction

    function automatic logic exp_led();
        return (m_st == TIMING);
    endfunction

    task automatic cyc(input logic s, input logic st, input logic cl, input logic r);
        if (r || cl) begin
            m_st   = IDLE;
            m_hold = 14'd0;
        end else begin
            case (m_st)
                IDLE: if (s) begin
                    m_e  = now + 1;
                    m_t  = m_e + TD * (MIN + int'(m_lfsr[DB-1:0]));
                    m_st = WAIT;
                end
                WAIT: if (st) begin
                    m_st   = CHEAT;
                    m_hold = CHEAT_CODE;
                end else if (now + 1 == m_t) begin
                    m_st = TIMING;
                end
                TIMING: if (st) begin
                    m_hold = exp_time();
                    m_st   = DONE;
                end else if (now + 1 - m_t >= TD * TO) begin
                    m_st   = TIMEOUT;
                    m_hold = 14'(TO);
                end
                default: ;
            endcase
        end
        start = s; stop = st; clear = cl; reset = r;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; reset = 1'b0;
        m_lfsr = r ? 16'hACE1 : lfsr_next(m_lfsr);
        now++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Returns number of cycles spent waiting for the LED; -1 on timeout.
    task automatic wait_led(output int n);
        n = 0;
        while (led !== 1'b1 && n < 100) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        asserts++;
        if (led !== 1'b1) begin
            $display("FAIL wait_led: led=%0b after %0d cycles, required 1", led, n);
            fails++;
            n = -1;
        end
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        asserts++;
        if (state !== IDLE) begin $display("FAIL reset_state: got %0d required %0d", state, IDLE); fails++; end
        asserts++;
        if (led !== 1'b0) begin $display("FAIL reset_led: got %0b required 0", led); fails++; end
        asserts++;
        if (time_ms !== 14'd0) begin $display("FAIL reset_time: got %0d required 0", time_ms); fails++; end
        asserts++;
        if (dut.lfsr_val !== 16'hACE1) begin $display("FAIL reset_lfsr: got %h required ace1", dut.lfsr_val); fails++; end
    endtask

    task automatic test_seeded_wait();
        int n;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        asserts++;
        if (state !== WAIT) begin $display("FAIL start_latency: got %0d required %0d", state, WAIT); fails++; end
        wait_led(n);
        asserts++;
        if (n != 12) begin $display("FAIL led_rise_cycles: got %0d required 12", n); fails++; end
        asserts++;
        if (time_ms !== 14'd0 || state !== TIMING) begin
            $display("FAIL led_rise_state: time=%0d state=%0d required 0/%0d", time_ms, state, TIMING); fails++;
        end
    endtask

    task automatic test_normal();
        idle_cycles(13);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (state !== DONE || time_ms !== 14'd3 || led !== 1'b0) begin
            $display("FAIL normal_done: state=%0d time=%0d led=%0b required %0d/3/0", state, time_ms, led, DONE); fails++;
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(6);
        asserts++;
        if (state !== DONE || time_ms !== 14'd3 || led !== 1'b0) begin
            $display("FAIL done_hold: state=%0d time=%0d led=%0b required %0d/3/0", state, time_ms, led, DONE); fails++;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        asserts++;
        if (state !== IDLE || time_ms !== 14'd0) begin
            $display("FAIL done_clear: state=%0d time=%0d required %0d/0", state, time_ms, IDLE); fails++;
        end
    endtask

    task automatic test_cheat();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (state !== CHEAT || time_ms !== 14'd9999 || led !== 1'b0) begin
            $display("FAIL cheat: state=%0d time=%0d led=%0b required %0d/9999/0", state, time_ms, led, CHEAT); fails++;
        end
        idle_cycles(40);
        asserts++;
        if (state !== CHEAT || led !== 1'b0) begin
            $display("FAIL cheat_hold: state=%0d led=%0b required %0d/0", state, led, CHEAT); fails++;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wait_led(n);
        idle_cycles(39);
        asserts++;
        if (state !== TIMING || time_ms !== 14'd9) begin
            $display("FAIL pre_timeout: state=%0d time=%0d required %0d/9", state, time_ms, TIMING); fails++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        asserts++;
        if (state !== TIMEOUT || time_ms !== 14'd10 || led !== 1'b0) begin
            $display("FAIL timeout: state=%0d time=%0d led=%0b required %0d/10/0", state, time_ms, led, TIMEOUT); fails++;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        int n;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wait_led(n);
        idle_cycles(7);
        // This cycle is a tick (prescaler at TD-1); stop must suppress the increment.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (state !== DONE || time_ms !== 14'd1) begin
            $display("FAIL stop_on_tick: state=%0d time=%0d required %0d/1", state, time_ms, DONE); fails++;
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycles(1);
        asserts++;
        if (state !== IDLE || time_ms !== 14'd0) begin
            $display("FAIL clear_beats_start: state=%0d time=%0d required %0d/0", state, time_ms, IDLE); fails++;
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        asserts++;
        if (state !== WAIT) begin
            $display("FAIL start_beats_stop: state=%0d required %0d", state, WAIT); fails++;
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_timing();
        int n;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wait_led(n);
        idle_cycles(20);
        asserts++;
        if (time_ms !== 14'd5) begin $display("FAIL mid_timing_time: got %0d required 5", time_ms); fails++; end
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        asserts++;
        if (state !== IDLE || led !== 1'b0 || time_ms !== 14'd0 || dut.lfsr_val !== 16'hACE1) begin
            $display("FAIL reset_mid_timing: state=%0d led=%0b time=%0d lfsr=%h required %0d/0/0/ace1",
                     state, led, time_ms, dut.lfsr_val, IDLE); fails++;
        end
    endtask

    task automatic test_random();
        int shown = 0;
        int bad;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(15) == 0), ($urandom_range(23) == 0),
                ($urandom_range(79) == 0), ($urandom_range(999) == 0));
            bad = 0;
            asserts += 3;
            if (state !== m_st)        bad++;
            if (led !== exp_led())     bad++;
            if (time_ms !== exp_time()) bad++;
            fails += bad;
            if (bad != 0 && shown < 10) begin
                shown++;
                $display("FAIL random_cycle_%0d: state=%0d led=%0b time=%0d required %0d/%0b/%0d",
                         i, state, led, time_ms, m_st, exp_led(), exp_time());
            end
        end
    endtask

    initial begin
        now    = 0;
        m_lfsr = 16'hACE1;
        m_st   = IDLE;
        m_hold = 14'd0;
        m_e    = 0;
        m_t    = 0;
        test_reset();
        test_seeded_wait();
        test_normal();
        test_cheat();
        test_timeout();
        test_simultaneous();
        test_reset_mid_timing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
